// File: rtl/pipelined_carry_adder.sv
// Pipelined WIDTH-bit adder built from STAGES registered ripple chunks with a valid/ready handshake.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module pipelined_carry_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
`ifdef PIPE_ADDER_OVF_EN
  output logic             Ovf,
`endif
  output logic             Cout
);

  localparam int CW = WIDTH / STAGES;

  // Bit-serial ripple add of one chunk; result is {carry_out, sum}.
  function automatic logic [CW:0] ripple_add(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                             input logic ci);
    logic          c;
    logic [CW-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < CW; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [CW:0]       res_s;
  logic              adv;
`ifdef PIPE_ADDER_OVF_EN
  logic              ovf_q;
  logic              ovf_d;
`endif

  // A single global advance keeps every beat in lock-step; bubbles are never collapsed.
  assign adv       = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = adv && !rst;
  assign out_valid = valid_q[STAGES-1];
  assign Sum       = sum_q[STAGES-1];
  assign Cout      = carry_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
  assign Ovf       = ovf_q;
`endif

  always_comb begin
    res_s      = ripple_add(A[CW-1:0], B[CW-1:0], Cin);
    a_d[0]     = A;
    b_d[0]     = B;
    sum_d[0]   = '0;
    sum_d[0][CW-1:0] = res_s[CW-1:0];
    carry_d[0] = res_s[CW];
    valid_d[0] = in_valid;
    // Stage k finishes chunk k of the beat held in stage k-1; earlier sum chunks ride along.
    for (int k = 1; k < STAGES; k++) begin
      res_s      = ripple_add(a_q[k-1][k*CW +: CW], b_q[k-1][k*CW +: CW], carry_q[k-1]);
      a_d[k]     = a_q[k-1];
      b_d[k]     = b_q[k-1];
      sum_d[k]   = sum_q[k-1];
      sum_d[k][k*CW +: CW] = res_s[CW-1:0];
      carry_d[k] = res_s[CW];
      valid_d[k] = valid_q[k-1];
    end
`ifdef PIPE_ADDER_OVF_EN
    ovf_d = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      carry_q <= carry_d;
      valid_q <= valid_d;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
